memory_write_buffer: RTL

First-word-fall-through write buffer in the `clk_memory` domain that sits directly downstream of `data_loader`. It absorbs the `write_en`/`write_addr`/`write_data` pulses that `data_loader` emits, which have no backpressure. It presents them in order to a memory controller port using a valid/ready handshake. Words that arrive while the buffer is full are dropped and flagged, so the loader never stalls.

---
 rtl/memory_write_buffer.sv | 86 ++++++++
 1 files changed

// File: rtl/memory_write_buffer.sv
// First-word-fall-through write buffer between data_loader and a memory port.
// Words arriving while full are dropped and latch a sticky overflow flag.
module memory_write_buffer #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8
) (
   input  logic                       clk_memory,
   input  logic                       reset,
   input  logic                       write_en,
   input  logic [ADDR_WIDTH-1:0]      write_addr,
   input  logic [DATA_WIDTH-1:0]      write_data,
   output logic                       mem_wr,
   output logic [ADDR_WIDTH-1:0]      mem_addr,
   output logic [DATA_WIDTH-1:0]      mem_data,
   input  logic                       mem_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       idle,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   logic full;
   logic push;
   logic pop;

   always_comb begin
      full       = (count_q == FULL);
      pop        = (count_q != '0) && mem_ready;
      push       = write_en && (!full || pop);
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A full buffer only drops when no slot frees up on the same edge.
      if (write_en && full && !pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk_memory) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_memory) begin
      if (push && !reset) begin
         addr_q[wr_ptr_q] <= write_addr;
         data_q[wr_ptr_q] <= write_data;
      end
   end

   assign mem_wr   = (count_q != '0);
   assign mem_addr = addr_q[rd_ptr_q];
   assign mem_data = data_q[rd_ptr_q];
   assign count    = count_q;
   assign idle     = (count_q == '0);
   assign overflow = overflow_q;

endmodule
